// File: rtl/seq_detector.sv
// Serial bit-pattern detector: a Mealy FSM over PAT_W prefix states, with an optional saturating hit counter.
// The hit counter is built only when SEQ_DETECTOR_HIT_CNT_EN is defined; otherwise hit_cnt/cnt_sat read as 0.
module seq_detector #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat
);

    localparam int SW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
        $error("seq_detector: PAT_W=%0d is outside 2..16", PAT_W);
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("seq_detector: CNT_W=%0d is outside 1..32", CNT_W);
    end

    typedef enum logic [SW-1:0] {
        S0     = SW'(0),
        S_LAST = SW'(PAT_W - 1)
    } state_t;

    state_t state;
    state_t state_next;

    // Longest pattern prefix that is a suffix of (first k pattern bits, b); capped at PAT_W-1,
    // which on a completed match yields the overlap fallback state, or S0 when overlap is off.
    function automatic int next_of(input int k, input logic b);
        logic [16:0] s;
        int          len;
        int          best;
        logic        ok;
        s = '0;
        for (int i = 0; i < k; i++) s[i] = PATTERN[PAT_W-1-i];
        s[k] = b;
        len  = k + 1;
        best = 0;
        for (int j = 1; j < PAT_W; j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (PATTERN[PAT_W-1-i] != s[len-j+i]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        if (k == PAT_W - 1 && b == PATTERN[0] && !OVERLAP) best = 0;
        return best;
    endfunction

    logic [SW-1:0] next_on0 [PAT_W];
    logic [SW-1:0] next_on1 [PAT_W];

    for (genvar k = 0; k < PAT_W; k++) begin : g_table
        localparam int N0 = next_of(k, 1'b0);
        localparam int N1 = next_of(k, 1'b1);
        assign next_on0[k] = SW'(N0);
        assign next_on1[k] = SW'(N1);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) state <= S0;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        match      = 1'b0;
        if (in_valid && areset) begin
            match      = (state == S_LAST) && (in == PATTERN[0]);
            state_next = state_t'(in ? next_on1[state] : next_on0[state]);
        end
    end

`ifdef SEQ_DETECTOR_HIT_CNT_EN
    // Clear has priority over a simultaneous match; a match at full scale only raises the sticky flag.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            hit_cnt <= '0;
            cnt_sat <= 1'b0;
        end else if (cnt_clr) begin
            hit_cnt <= '0;
            cnt_sat <= 1'b0;
        end else if (match) begin
            if (hit_cnt == {CNT_W{1'b1}}) cnt_sat <= 1'b1;
            else                          hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign hit_cnt        = '0;
    assign cnt_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: four parameterisations share one input stream and are
// compared against a sliding-window reference model.
module tb_seq_detector;

`ifdef SEQ_DETECTOR_HIT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset = 1'b0;
    logic in_valid = 1'b0;
    logic in = 1'b0;
    logic cnt_clr = 1'b0;

    logic [3:0] act_match;
    logic [3:0] act_sat;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;
    int         act_cnt [4];

    int errors = 0;
    int checks = 0;

    // Instance configs: 0 = 1011 overlap, 1 = 1011 non-overlap, 2 = 11 overlap, 3 = 1011 with 2-bit counter
    int cfg_w   [4] = '{4, 4, 2, 4};
    int cfg_pat [4] = '{11, 11, 3, 11};
    bit cfg_ovl [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int cfg_max [4] = '{255, 255, 255, 3};

    logic [31:0] m_hist [4];
    int          m_n    [4];
    int          m_cnt  [4];
    bit          m_sat  [4];
    bit          exp_match [4];

    always #5 clk = ~clk;

    seq_detector dut_ovl (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
        .match(act_match[0]), .hit_cnt(cnt0), .cnt_sat(act_sat[0]));
    seq_detector #(.OVERLAP(1'b0)) dut_nov (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
        .match(act_match[1]), .hit_cnt(cnt1), .cnt_sat(act_sat[1]));
    seq_detector #(.PAT_W(2), .PATTERN(2'b11)) dut_two (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
        .match(act_match[2]), .hit_cnt(cnt2), .cnt_sat(act_sat[2]));
    seq_detector #(.CNT_W(2)) dut_sat (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
        .match(act_match[3]), .hit_cnt(cnt3), .cnt_sat(act_sat[3]));

    always_comb begin
        act_cnt[0] = 32'(cnt0);
        act_cnt[1] = 32'(cnt1);
        act_cnt[2] = 32'(cnt2);
        act_cnt[3] = 32'(cnt3);
    end

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = '0;
            m_n[i]    = 0;
            m_cnt[i]  = 0;
            m_sat[i]  = 1'b0;
            exp_match[i] = 1'b0;
        end
    endtask

    // A match is a full pattern in the last PAT_W bits consumed since the last restart point.
    task automatic predict();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] win;
            win = ((m_hist[i] << 1) | 32'(in)) & ((32'd1 << cfg_w[i]) - 32'd1);
            exp_match[i] = areset && in_valid && (m_n[i] + 1 >= cfg_w[i]) && (win == 32'(cfg_pat[i]));
        end
    endtask

    task automatic advance();
        for (int i = 0; i < 4; i++) begin
            if (areset && in_valid) begin
                if (exp_match[i] && !cfg_ovl[i]) begin
                    m_hist[i] = '0;
                    m_n[i]    = 0;
                end else begin
                    m_hist[i] = (m_hist[i] << 1) | 32'(in);
                    if (m_n[i] < 1000) m_n[i]++;
                end
            end
            if (CNT_EN && areset) begin
                if (cnt_clr) begin
                    m_cnt[i] = 0;
                    m_sat[i] = 1'b0;
                end else if (exp_match[i]) begin
                    if (m_cnt[i] == cfg_max[i]) m_sat[i] = 1'b1;
                    else                        m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input bit b, input bit clr);
        in_valid = v;
        in       = b;
        cnt_clr  = clr;
        #2;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic apply_reset();
        areset   = 1'b0;
        in_valid = 1'b0;
        in       = 1'b0;
        cnt_clr  = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        areset = 1'b1;
    endtask

    task automatic test_reset();
        areset   = 1'b0;
        in_valid = 1'b1;
        in       = 1'b1;
        clear_model();
        #2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act_match[i] !== 1'b0 || act_cnt[i] !== 0 || act_sat[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: match=%b cnt=%0d sat=%b, want 0/0/0",
                         i, act_match[i], act_cnt[i], act_sat[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act_match[i] !== 1'b0 || act_cnt[i] !== 0 || act_sat[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_clocked dut%0d: match=%b cnt=%0d sat=%b, want 0/0/0",
                         i, act_match[i], act_cnt[i], act_sat[i]);
            end
        end
        in_valid = 1'b0;
        areset   = 1'b1;
    endtask

    task automatic test_overlap();
        bit stream   [7] = '{1, 0, 1, 1, 0, 1, 1};
        bit want_ovl [7] = '{0, 0, 0, 1, 0, 0, 1};
        bit want_nov [7] = '{0, 0, 0, 1, 0, 0, 0};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, stream[k], 1'b0);
            checks++;
            if (act_match[0] !== want_ovl[k] || act_match[1] !== want_nov[k]) begin
                errors++;
                $display("[TB] FAIL overlap bit%0d: ovl=%b nov=%b, want %b %b",
                         k + 1, act_match[0], act_match[1], want_ovl[k], want_nov[k]);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_match[i] !== exp_match[i]) begin
                    errors++;
                    $display("[TB] FAIL overlap_model dut%0d bit%0d: match=%b want %b",
                             i, k + 1, act_match[i], exp_match[i]);
                end
            end
            tick();
        end
        checks++;
        if (act_cnt[0] !== (CNT_EN ? 2 : 0) || act_cnt[1] !== (CNT_EN ? 1 : 0)) begin
            errors++;
            $display("[TB] FAIL overlap_count: ovl=%0d nov=%0d, want %0d %0d",
                     act_cnt[0], act_cnt[1], CNT_EN ? 2 : 0, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_valid_gating();
        bit vs [7] = '{1, 1, 1, 0, 0, 0, 1};
        bit bs [7] = '{1, 0, 1, 0, 0, 0, 1};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            drive(vs[k], bs[k], 1'b0);
            checks++;
            if (act_match[0] !== (k == 6)) begin
                errors++;
                $display("[TB] FAIL valid_gating step%0d: match=%b want %b", k, act_match[0], k == 6);
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (act_match[i] !== exp_match[i]) begin
                    errors++;
                    $display("[TB] FAIL valid_gating_model dut%0d step%0d: match=%b want %b",
                             i, k, act_match[i], exp_match[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bit pre  [7] = '{1, 0, 1, 1, 1, 0, 1};
        bit post [4] = '{1, 0, 1, 1};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, pre[k], 1'b0);
            tick();
        end
        // Assert reset between clock edges: counters must clear with no clock edge
        in_valid = 1'b0;
        #2;
        areset = 1'b0;
        clear_model();
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act_match[i] !== 1'b0 || act_cnt[i] !== 0 || act_sat[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL async_reset dut%0d: match=%b cnt=%0d sat=%b, want 0/0/0",
                         i, act_match[i], act_cnt[i], act_sat[i]);
            end
        end
        @(posedge clk);
        #1;
        areset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, post[k], 1'b0);
            checks++;
            if (act_match[0] !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL reset_mid bit%0d: match=%b want %b", k + 1, act_match[0], k == 3);
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (act_match[i] !== exp_match[i]) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_model dut%0d bit%0d: match=%b want %b",
                             i, k + 1, act_match[i], exp_match[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        bit pat [4] = '{1, 0, 1, 1};
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, pat[k], 1'b0);
                tick();
            end
        end
        checks++;
        if (act_cnt[3] !== (CNT_EN ? 3 : 0) || act_sat[3] !== CNT_EN || act_cnt[0] !== (CNT_EN ? 5 : 0)) begin
            errors++;
            $display("[TB] FAIL saturation: sat_cnt=%0d sat=%b wide_cnt=%0d, want %0d %b %0d",
                     act_cnt[3], act_sat[3], act_cnt[0], CNT_EN ? 3 : 0, CNT_EN, CNT_EN ? 5 : 0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, pat[k], k == 3);
            if (k == 3) begin
                checks++;
                if (act_match[3] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL clear_match: match=%b want 1", act_match[3]);
                end
            end
            tick();
        end
        checks++;
        if (act_cnt[3] !== 0 || act_sat[3] !== 1'b0 || act_cnt[0] !== 0) begin
            errors++;
            $display("[TB] FAIL clear_wins: sat_cnt=%0d sat=%b wide_cnt=%0d, want 0 0 0",
                     act_cnt[3], act_sat[3], act_cnt[0]);
        end
    endtask

    task automatic test_two_bit();
        bit stream [5] = '{0, 1, 1, 1, 0};
        bit want   [5] = '{0, 0, 1, 1, 0};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, stream[k], 1'b0);
            checks++;
            if (act_match[2] !== want[k]) begin
                errors++;
                $display("[TB] FAIL two_bit bit%0d: match=%b want %b", k + 1, act_match[2], want[k]);
            end
            tick();
        end
        checks++;
        if (act_cnt[2] !== (CNT_EN ? 2 : 0)) begin
            errors++;
            $display("[TB] FAIL two_bit_count: cnt=%0d want %0d", act_cnt[2], CNT_EN ? 2 : 0);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(99) == 0) begin
                apply_reset();
            end
            drive($urandom_range(3) != 0, 1'($urandom), $urandom_range(19) == 0);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_match[i] !== exp_match[i]) begin
                    errors++;
                    $display("[TB] FAIL random_match dut%0d cycle%0d: match=%b want %b",
                             i, k, act_match[i], exp_match[i]);
                end
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_cnt[i] !== m_cnt[i] || act_sat[i] !== m_sat[i]) begin
                    errors++;
                    $display("[TB] FAIL random_count dut%0d cycle%0d: cnt=%0d sat=%b want %0d %b",
                             i, k, act_cnt[i], act_sat[i], m_cnt[i], m_sat[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_valid_gating();
        test_reset_mid();
        test_saturation();
        test_two_bit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011, PAT_W bits wide: target sequence; PATTERN[PAT_W-1] is the first bit received, PATTERN[0] the last.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches counted; 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8: hit counter width, legal range 1..32.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 areset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  qualifies in; the bit is consumed only on cycles where in_valid=1.
REQ-008 in  input  1  serial data bit.
REQ-009 cnt_clr  input  1  synchronous clear of hit_cnt and cnt_sat.
REQ-010 match  output  1  Mealy detect flag, combinational from the current state, in_valid and in.
REQ-011 hit_cnt  output  CNT_W  registered count of matches.
REQ-012 cnt_sat  output  1  registered sticky flag: hit_cnt has saturated.

Function
REQ-013 The FSM SHALL have PAT_W states S0..S(PAT_W-1); Sk means the last k consumed bits equal the first k pattern bits.
REQ-014 The state SHALL be held unchanged on any cycle with in_valid=0.
REQ-015 With in_valid=1 in state Sk (k<PAT_W-1), the next state SHALL be Sj, where j is the length of the longest pattern prefix that is a suffix of (the k matched bits followed by in).
REQ-016 match SHALL equal in_valid AND (state==S(PAT_W-1)) AND (in==PATTERN[0]), in the same cycle, with zero latency.
REQ-017 When match=1 and OVERLAP=1, the next state SHALL be Sf, where f is the length of the longest proper prefix of PATTERN that is also its suffix.
REQ-018 When match=1 and OVERLAP=0, the next state SHALL be S0.
REQ-019 When state==S(PAT_W-1) with in_valid=1 and match=0, the next state SHALL follow the REQ-015 rule.
REQ-020 The transition table SHALL be derived from the parameters at elaboration time; no runtime pattern load exists.
REQ-021 hit_cnt SHALL increment by 1 on the clock edge that ends a cycle with match=1, saturating at 2^CNT_W-1.
REQ-022 cnt_sat SHALL set on the edge where hit_cnt would exceed 2^CNT_W-1, and SHALL stay set until cnt_clr or reset.
REQ-023 When cnt_clr=1 and match=1 in the same cycle, the clear SHALL win: hit_cnt=0 and cnt_sat=0 next cycle.
REQ-024 cnt_clr SHALL NOT affect the FSM state or match.
REQ-025 An illegal PAT_W or CNT_W SHALL cause an elaboration error.

Reset
REQ-026 While areset=0, the state SHALL be S0, hit_cnt=0 and cnt_sat=0, asynchronously and independent of clk.
REQ-027 match SHALL be 0 while areset=0.
REQ-028 A reset mid-sequence SHALL discard all partial progress; detection restarts from S0 on the first valid bit after release.

Configuration
REQ-029 Macro SEQ_DETECTOR_HIT_CNT_EN defined: the hit_cnt and cnt_sat logic SHALL be present, as specified in REQ-021..REQ-023.
REQ-030 Macro SEQ_DETECTOR_HIT_CNT_EN undefined: hit_cnt and cnt_sat SHALL be tied to 0, no counter flops SHALL exist, cnt_clr SHALL be ignored, and the FSM and match SHALL be unchanged.

Verification
REQ-031 Overlap test: PAT_W=4, PATTERN=1011, OVERLAP=1; stream 1,0,1,1,0,1,1 with in_valid=1 -> match=1 on bits 4 and 7 only; hit_cnt=2.
REQ-032 Non-overlap test: same stream with OVERLAP=0 -> match=1 on bit 4 only; hit_cnt=1.
REQ-033 Valid gating: stream 1,0,1,(in_valid=0 for 3 cycles with in=0),1 -> state held in S3; match=1 on the final valid bit.
REQ-034 Reset mid-stream: consume 1,0,1; pulse areset=0 for 1 cycle; then 1 -> match=0; the state after the final bit is S1.
REQ-035 Saturation: CNT_W=2, 5 matches -> hit_cnt=3 and cnt_sat=1; then cnt_clr=1 during a match -> hit_cnt=0 and cnt_sat=0.
REQ-036 Two-bit case: PAT_W=2, PATTERN=11, OVERLAP=1; stream 0,1,1,1,0 -> match=1 on bits 3 and 4.
